clk_skew_port: RTL and testbench
================================

CLK_SKEW_PORT -- requirements
Module: clk_skew_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 2, number of parallel channels sharing one skew setting.
REQ-003 SHALL have parameter MAX_SKEW, default 7, largest programmable skew in cycles; SW = ceil(log2(MAX_SKEW+1)).
REQ-004 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_we  in  1  skew update request.
REQ-007 SHALL have port cfg_in_skew  in  SW  requested input skew.
REQ-008 SHALL have port cfg_out_skew  in  SW  requested output skew.
REQ-009 SHALL have port pin_in  in  CHANNELS*WIDTH  raw sampled signals.
REQ-010 SHALL have port samp_data  out  CHANNELS*WIDTH  skewed samples.
REQ-011 SHALL have port samp_valid  out  1  samp_data is meaningful.
REQ-012 SHALL have ports drv_valid in 1, drv_ready out 1, drv_data in CHANNELS*WIDTH: drive request handshake.
REQ-013 SHALL have port pin_out  out  CHANNELS*WIDTH  driven value; pin_oe  out  1  drive strobe.
REQ-014 SHALL have port busy  out  1  high whenever FSM is not RUN.
REQ-015 SHALL have port drv_count  out  16  accepted-drive statistic.

Function
REQ-016 SHALL implement samp_data(t) = pin_in(t - in_skew - 1) from a MAX_SKEW+1 deep delay line, all channels identical.
REQ-017 SHALL accept a drive on a clk edge where drv_valid && drv_ready; at most one accept per cycle, back-to-back accepts fully pipelined.
REQ-018 SHALL present an accepted drv_data on pin_out exactly out_skew+1 edges after acceptance, with pin_oe high for exactly that one cycle.
REQ-019 SHALL hold pin_out at last driven value when pin_oe is low.
REQ-020 SHALL implement FSM states RUN, DRAIN, WARM; drv_ready = 1 only in RUN.
REQ-021 SHALL, on cfg_we in RUN, capture both requested skews into shadow registers and go to DRAIN; cfg_we in DRAIN or WARM SHALL be ignored.
REQ-022 SHALL clamp any requested skew above MAX_SKEW to MAX_SKEW.
REQ-023 SHALL, in RUN with drv_valid and cfg_we together, accept the drive and still enter DRAIN; that drive completes with the old out_skew.
REQ-024 SHALL leave DRAIN for WARM on the first cycle with no drive in flight, loading shadow skews into active skews on that transition.
REQ-025 SHALL hold samp_valid low in DRAIN and for in_skew+1 cycles of WARM, then enter RUN with samp_valid high.
REQ-026 SHALL keep in-flight drives completing unchanged during DRAIN.

Reset
REQ-027 SHALL on rst force: samp_data 0, samp_valid 0, pin_out 0, pin_oe 0, drv_ready 0, busy 1, drv_count 0, active and shadow skews 0, state WARM, delay lines and in-flight drives cleared.
REQ-028 SHALL, on rst mid-operation, discard all in-flight drives with no pin_oe pulse; after release, RUN is reached after 1 cycle (skew 0).

Configuration
REQ-029 SHALL, with CLK_SKEW_PORT_STATS_EN defined, increment drv_count per accepted drive, saturating at 0xFFFF; without it drv_count SHALL be constant 0 and no counter logic synthesised.

Structure
REQ-030 SHALL place FSM state enum and default parameter constants in package clk_skew_port_pkg.
REQ-031 SHALL use one sub-module, clk_skew_delay, a parametrised variable-tap delay line instantiated for the input path and the output data/strobe path.

Verification
REQ-032 Reset, in_skew=0, pin_in ramps 1,2,3 -> samp_data 1,2,3 one cycle late, samp_valid high from cycle 1.
REQ-033 cfg_we with in=3,out=2, no drives -> busy high, samp_valid low 4 WARM cycles, then samp_data lags pin_in by 4.
REQ-034 out_skew=2, drives 0xA1,0xA2,0xA3 back-to-back -> pin_oe high 3 consecutive cycles starting 3 edges after first accept, pin_out A1,A2,A3 then held A3.
REQ-035 out_skew=5, drive accepted same cycle as cfg_we(out=0) -> drive appears 6 edges later, drv_ready low until WARM ends, next drive lags 1 edge.
REQ-036 cfg_out_skew=15 with MAX_SKEW=7 -> behaves as 7 (8-edge latency).
REQ-037 rst asserted with 2 drives in flight -> no pin_oe pulse; with STATS_EN, 70000 drives -> drv_count = 0xFFFF.

Source files
------------

// File: rtl/clk_skew_port_pkg.sv
// Shared types and default constants for the skewed sample/drive port.
package clk_skew_port_pkg;

   localparam int WIDTH_DEF    = 8;
   localparam int CHANNELS_DEF = 2;
   localparam int MAX_SKEW_DEF = 7;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WARM  = 2'd2
   } state_e;

   // Requests above the delay-line depth saturate to the deepest tap.
   function automatic int clamp_skew(input int req, input int max_skew);
      return (req > max_skew) ? max_skew : req;
   endfunction

endpackage

// File: rtl/clk_skew_delay.sv
// Variable-tap delay line: q = d delayed by sel+1 clock edges.
// Stages beyond the selected tap are flushed to zero so that stale entries
// cannot resurface when the tap is later moved deeper.
module clk_skew_delay #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int SW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d,
   input  logic [SW-1:0] sel,
   output logic [DW-1:0] q
);

   logic [DW-1:0] sr_q [DEPTH];
   logic [DW-1:0] sr_d [DEPTH];

   // Shift one stage per cycle, zero-fill everything past the active tap.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         sr_d[i] = '0;
      end
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         if (i <= int'(sel)) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= sr_d[i];
         end
      end
   end

   assign q = sr_q[sel];

endmodule

// File: rtl/clk_skew_port.sv
// Skewed sample/drive port: a programmable input sampling delay and a
// programmable output drive delay, retuned through a DRAIN/WARM sequence.
// Optional build macro: CLK_SKEW_PORT_STATS_EN enables the drv_count statistic.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, drives accepted, samples valid
// ST_DRAIN | new skews latched in shadow, waiting for in-flight drives
// ST_WARM  | new skews active, input delay line refilling (in_skew+1)
module clk_skew_port
   import clk_skew_port_pkg::*;
#(
   parameter  int WIDTH    = WIDTH_DEF,
   parameter  int CHANNELS = CHANNELS_DEF,
   parameter  int MAX_SKEW = MAX_SKEW_DEF,
   localparam int SW       = (MAX_SKEW < 1) ? 1 : $clog2(MAX_SKEW + 1),
   localparam int DW       = CHANNELS * WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [SW-1:0] cfg_in_skew,
   input  logic [SW-1:0] cfg_out_skew,
   input  logic [DW-1:0] pin_in,
   output logic [DW-1:0] samp_data,
   output logic          samp_valid,
   input  logic          drv_valid,
   output logic          drv_ready,
   input  logic [DW-1:0] drv_data,
   output logic [DW-1:0] pin_out,
   output logic          pin_oe,
   output logic          busy,
   output logic [15:0]   drv_count
);

   state_e        state_q, state_d;
   logic [SW-1:0] in_skew_q, in_skew_d;
   logic [SW-1:0] out_skew_q, out_skew_d;
   logic [SW-1:0] sh_in_q, sh_in_d;
   logic [SW-1:0] sh_out_q, sh_out_d;
   logic [SW-1:0] warm_cnt_q, warm_cnt_d;
   logic [SW:0]   inflight_q, inflight_d;
   logic [DW-1:0] pin_out_q, pin_out_d;
   logic          pin_oe_q, pin_oe_d;

   logic          accept;
   logic [DW:0]   out_tap;
   logic          tap_oe;
   logic [DW-1:0] tap_data;

   assign accept     = drv_valid && drv_ready;
   assign drv_ready  = (state_q == ST_RUN);
   assign samp_valid = (state_q == ST_RUN);
   assign busy       = (state_q != ST_RUN);

   clk_skew_delay #(.DW(DW), .DEPTH(MAX_SKEW + 1), .SW(SW)) u_in_dly (
      .clk (clk),
      .rst (rst),
      .d   (pin_in),
      .sel (in_skew_q),
      .q   (samp_data)
   );

   // Strobe travels alongside the data so each drive emerges exactly once.
   clk_skew_delay #(.DW(DW + 1), .DEPTH(MAX_SKEW + 1), .SW(SW)) u_out_dly (
      .clk (clk),
      .rst (rst),
      .d   ({accept, drv_data}),
      .sel (out_skew_q),
      .q   (out_tap)
   );

   assign {tap_oe, tap_data} = out_tap;

   // Retiming FSM: shadow capture, drain, skew swap and warm-up countdown.
   always_comb begin
      state_d    = state_q;
      in_skew_d  = in_skew_q;
      out_skew_d = out_skew_q;
      sh_in_d    = sh_in_q;
      sh_out_d   = sh_out_q;
      warm_cnt_d = warm_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_we) begin
               sh_in_d  = SW'(clamp_skew(int'(cfg_in_skew), MAX_SKEW));
               sh_out_d = SW'(clamp_skew(int'(cfg_out_skew), MAX_SKEW));
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (inflight_q == '0) begin
               in_skew_d  = sh_in_q;
               out_skew_d = sh_out_q;
               warm_cnt_d = sh_in_q;
               state_d    = ST_WARM;
            end
         end
         ST_WARM: begin
            if (warm_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               warm_cnt_d = warm_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_WARM;
      endcase
   end

   // Drive bookkeeping and output pin register (holds last driven value).
   always_comb begin
      inflight_d = inflight_q + (SW+1)'(accept) - (SW+1)'(tap_oe);
      pin_oe_d   = tap_oe;
      pin_out_d  = tap_oe ? tap_data : pin_out_q;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_WARM;
         in_skew_q  <= '0;
         out_skew_q <= '0;
         sh_in_q    <= '0;
         sh_out_q   <= '0;
         warm_cnt_q <= '0;
         inflight_q <= '0;
         pin_out_q  <= '0;
         pin_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_skew_q  <= in_skew_d;
         out_skew_q <= out_skew_d;
         sh_in_q    <= sh_in_d;
         sh_out_q   <= sh_out_d;
         warm_cnt_q <= warm_cnt_d;
         inflight_q <= inflight_d;
         pin_out_q  <= pin_out_d;
         pin_oe_q   <= pin_oe_d;
      end
   end

   assign pin_out = pin_out_q;
   assign pin_oe  = pin_oe_q;

`ifdef CLK_SKEW_PORT_STATS_EN
   logic [15:0] drv_count_q, drv_count_d;

   // Saturating count of accepted drives.
   always_comb begin
      drv_count_d = drv_count_q;
      if (accept && (drv_count_q != 16'hFFFF)) begin
         drv_count_d = drv_count_q + 16'd1;
      end
   end

   // Statistic register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drv_count_q <= '0;
      end else begin
         drv_count_q <= drv_count_d;
      end
   end

   assign drv_count = drv_count_q;
`else
   assign drv_count = '0;
`endif

endmodule

// File: tb/tb_clk_skew_port.sv
// Directed bench for clk_skew_port (default parameters).
module tb_clk_skew_port;

   localparam int SW = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [SW-1:0] cfg_in_skew;
   logic [SW-1:0] cfg_out_skew;
   logic [DW-1:0] pin_in;
   logic [DW-1:0] samp_data;
   logic          samp_valid;
   logic          drv_valid;
   logic          drv_ready;
   logic [DW-1:0] drv_data;
   logic [DW-1:0] pin_out;
   logic          pin_oe;
   logic          busy;
   logic [15:0]   drv_count;

   int n_cmp = 0;
   int n_bad = 0;

   clk_skew_port u_dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_in_skew  (cfg_in_skew),
      .cfg_out_skew (cfg_out_skew),
      .pin_in       (pin_in),
      .samp_data    (samp_data),
      .samp_valid   (samp_valid),
      .drv_valid    (drv_valid),
      .drv_ready    (drv_ready),
      .drv_data     (drv_data),
      .pin_out      (pin_out),
      .pin_oe       (pin_oe),
      .busy         (busy),
      .drv_count    (drv_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [SW-1:0] i_skew, input logic [SW-1:0] o_skew);
      cfg_we       = 1'b1;
      cfg_in_skew  = i_skew;
      cfg_out_skew = o_skew;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!drv_ready && n < 100) begin
         tick();
         n++;
      end
      chk(tag, drv_ready, 1);
   endtask

   function automatic logic [DW-1:0] pat(input logic [7:0] v);
      return {v ^ 8'h5A, v};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] hist [6];
      logic [DW-1:0] exp_out;
      logic          exp_oe;
      logic [15:0]   exp_cnt;
      int            n;
      int            pulses;

      rst = 1'b1; cfg_we = 1'b0; cfg_in_skew = '0; cfg_out_skew = '0;
      pin_in = '0; drv_valid = 1'b0; drv_data = '0;
      tick();
      tick();

      // Reset state
      chk("rst_samp_data", samp_data, 0);
      chk("rst_samp_valid", samp_valid, 0);
      chk("rst_pin_out", pin_out, 0);
      chk("rst_pin_oe", pin_oe, 0);
      chk("rst_drv_ready", drv_ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_drv_count", drv_count, 0);
      rst = 1'b0;

      // Skew 0: one-cycle sampling latency, valid from the first cycle
      for (int k = 1; k <= 3; k++) begin
         pin_in = pat(8'(k));
         tick();
         chk("ramp_data", samp_data, pat(8'(k)));
         chk("ramp_valid", samp_valid, 1);
      end

      // Retune in=3 out=2 with nothing in flight
      cfg(3'd3, 3'd2);
      chk("drain_busy", busy, 1);
      chk("drain_valid", samp_valid, 0);
      chk("drain_ready", drv_ready, 0);
      tick();
      n = 0;
      while (!samp_valid && n < 20) begin
         n++;
         tick();
      end
      chk("warm_len", n, 4);
      chk("run_busy", busy, 0);
      for (int k = 0; k < 6; k++) begin
         hist[k] = pat(8'(8'h40 + k));
         pin_in  = hist[k];
         tick();
         if (k >= 3) chk("lag4", samp_data, hist[k-3]);
      end

      // out_skew=2: three back-to-back drives
      for (int s = 0; s < 8; s++) begin
         if (s < 3) begin
            drv_valid = 1'b1;
            drv_data  = pat(8'(8'hA1 + s));
         end else begin
            drv_valid = 1'b0;
         end
         tick();
         exp_oe  = (s >= 3 && s <= 5);
         exp_out = (s < 3) ? '0 : (s <= 5) ? pat(8'(8'hA1 + s - 3)) : pat(8'hA3);
         chk("b2b_oe", pin_oe, exp_oe);
         chk("b2b_out", pin_out, exp_out);
      end

      // out_skew=5, drive accepted together with cfg_we(out=0)
      cfg(3'd0, 3'd5);
      wait_ready("ready_o5");
      drv_valid = 1'b1; drv_data = pat(8'hD5);
      cfg_we = 1'b1; cfg_in_skew = 3'd0; cfg_out_skew = 3'd0;
      tick();
      drv_valid = 1'b0; cfg_we = 1'b0;
      chk("same_cycle_busy", busy, 1);
      for (int s = 1; s <= 6; s++) begin
         tick();
         chk("o5_oe", pin_oe, (s == 6));
         chk("o5_ready", drv_ready, 0);
      end
      chk("o5_data", pin_out, pat(8'hD5));
      tick();
      chk("o5_warm_ready", drv_ready, 0);
      chk("o5_oe_once", pin_oe, 0);
      tick();
      chk("o5_run_ready", drv_ready, 1);
      drv_valid = 1'b1; drv_data = pat(8'hE7);
      tick();
      drv_valid = 1'b0;
      chk("o0_early", pin_oe, 0);
      tick();
      chk("o0_oe", pin_oe, 1);
      chk("o0_data", pin_out, pat(8'hE7));
      tick();
      chk("o0_done", pin_oe, 0);
      chk("o0_hold", pin_out, pat(8'hE7));

      // Maximum skew: 8-edge drive latency
      cfg(3'd7, 3'd7);
      wait_ready("ready_max");
      drv_valid = 1'b1; drv_data = pat(8'hF0);
      tick();
      drv_valid = 1'b0;
      n = 0;
      while (!pin_oe && n < 30) begin
         tick();
         n++;
      end
      chk("max_lat", n, 8);
      chk("max_data", pin_out, pat(8'hF0));

`ifdef CLK_SKEW_PORT_STATS_EN
      exp_cnt = 16'd6;
`else
      exp_cnt = 16'd0;
`endif
      chk("drv_count", drv_count, exp_cnt);

      // Reset with two drives in flight
      tick();
      drv_valid = 1'b1; drv_data = pat(8'h11);
      tick();
      drv_data = pat(8'h22);
      tick();
      drv_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_oe", pin_oe, 0);
      chk("mid_rst_pin_out", pin_out, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_count", drv_count, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", samp_valid, 1);
      pulses = 0;
      for (int s = 0; s < 12; s++) begin
         if (pin_oe) pulses++;
         tick();
      end
      chk("post_rst_no_oe", pulses, 0);

`ifdef CLK_SKEW_PORT_STATS_EN
      drv_valid = 1'b1; drv_data = pat(8'h33);
      for (int s = 0; s < 70000; s++) tick();
      drv_valid = 1'b0;
      chk("count_sat", drv_count, 16'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
